// File: rtl/vscale_uart_tx_ctrl_if.sv
// Byte write channel between the UART register block and the TXD transmit controller.
// The register block drives valid/data; the transmit controller answers with ready.
interface vscale_uart_tx_ctrl_if;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;

    modport master (
        output wr_valid,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/vscale_uart_tx_ctrl.sv
// TXD transmit controller: small byte FIFO feeding an 8N1 serializer timed by a
// down-counting baud timer. TXD always comes straight from a flop.
//
// state | meaning
// IDLE  | line high, waiting for tx_en and a queued byte
// START | start bit (low) for one bit time
// DATA  | eight data bits, LSB first, shifted out of shift_q
// STOP  | stop bit (high); may chain straight into the next START
module vscale_uart_tx_ctrl #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        tx_en,
    vscale_uart_tx_ctrl_if.slave        wr,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        busy,
    output logic                        TXD
);

    localparam int             PW     = $clog2(FIFO_DEPTH);
    localparam logic [15:0]    RELOAD = 16'(CLKS_PER_BIT - 1);
    localparam logic [PW:0]    FULL   = (PW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   count_q;
    logic [PW:0]   count_d;
    logic          ready_q;

    state_t        state_q;
    logic [15:0]   cnt_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic          txd_q;

    logic          push;
    logic          pop;
    logic          cnt_zero;
    logic          have_byte;
    logic [7:0]    head;

    always_comb begin
        have_byte = tx_en && (count_q != '0);
        cnt_zero  = (cnt_q == 16'd0);
        pop       = have_byte && ((state_q == IDLE) || ((state_q == STOP) && cnt_zero));
        push      = wr.wr_valid && ready_q;
        head      = mem_q[rd_ptr_q];
        count_d   = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // ready is registered so a pop on the full edge frees a slot only from the next cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;
            ready_q <= (count_d != FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            cnt_q     <= 16'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            txd_q     <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    txd_q <= 1'b1;
                    if (pop) begin
                        shift_q <= head;
                        cnt_q   <= RELOAD;
                        state_q <= START;
                        txd_q   <= 1'b0;
                    end
                end
                START: begin
                    if (cnt_zero) begin
                        cnt_q     <= RELOAD;
                        bit_idx_q <= 3'd0;
                        state_q   <= DATA;
                        txd_q     <= shift_q[0];
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                DATA: begin
                    if (cnt_zero) begin
                        cnt_q   <= RELOAD;
                        shift_q <= {1'b0, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
                            state_q <= STOP;
                            txd_q   <= 1'b1;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            txd_q     <= shift_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                STOP: begin
                    if (cnt_zero) begin
                        if (pop) begin
                            shift_q <= head;
                            cnt_q   <= RELOAD;
                            state_q <= START;
                            txd_q   <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                            txd_q   <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    txd_q   <= 1'b1;
                end
            endcase
        end
    end

    assign wr.wr_ready = ready_q;
    assign fifo_count  = count_q;
    assign busy        = (state_q != IDLE) || (count_q != '0);
    assign TXD         = txd_q;

endmodule

// File: tb/tb_vscale_uart_tx_ctrl.sv
// Bench for vscale_uart_tx_ctrl: frame-level reference model plus a serial decoder
// that pops expected bytes from a scoreboard queue.
module tb_vscale_uart_tx_ctrl;
    localparam int C     = 4;
    localparam int D     = 4;
    localparam int FRAME = 10 * C;

    logic                clk  = 1'b0;
    logic                rstn = 1'b0;
    logic                tx_en = 1'b0;
    logic [$clog2(D):0]  fifo_count;
    logic                busy;
    logic                TXD;

    vscale_uart_tx_ctrl_if wif();

    vscale_uart_tx_ctrl #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .tx_en      (tx_en),
        .wr         (wif.slave),
        .fifo_count (fifo_count),
        .busy       (busy),
        .TXD        (TXD)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // reference model: bytes waiting, frame in flight, cycles elapsed in that frame
    logic [7:0] m_q[$];
    logic [7:0] sb_q[$];
    bit         m_frame;
    int         m_k;
    logic [7:0] m_byte;
    bit         m_ready;
    bit         m_acc;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_q.delete();
            sb_q.delete();
            m_frame = 0;
            m_k     = 0;
            m_ready = 0;
        end else begin
            m_acc = wif.wr_valid && m_ready;
            if (m_frame) begin
                m_k++;
                if (m_k == FRAME) m_frame = 0;
            end
            if (!m_frame && tx_en && m_q.size() != 0) begin
                m_byte  = m_q.pop_front();
                m_frame = 1;
                m_k     = 0;
            end
            if (m_acc) begin
                m_q.push_back(wif.wr_data);
                sb_q.push_back(wif.wr_data);
            end
            m_ready = (m_q.size() != D);
        end
    end

    function automatic int exp_txd();
        int b;
        if (!m_frame) return 1;
        b = m_k / C;
        if (b == 0) return 0;
        if (b == 9) return 1;
        return int'(m_byte[b-1]);
    endfunction

    always @(negedge clk) begin
        check("txd", int'(TXD), exp_txd());
        check("fifo_count", int'(fifo_count), m_q.size());
        check("busy", int'(busy), int'(m_frame || m_q.size() != 0));
        check("wr_ready", int'(wif.wr_ready), int'(m_ready));
    end

    // serial decoder: samples one cycle into each bit, scores the byte at the stop bit
    bit         d_act = 0;
    int         d_n   = 0;
    int         d_idx;
    logic [7:0] d_byte;
    logic [7:0] d_exp;

    always @(negedge clk) begin
        if (!rstn) begin
            d_act = 0;
        end else if (!d_act) begin
            if (TXD == 1'b0) begin
                d_act = 1;
                d_n   = 0;
            end
        end else begin
            d_n++;
            if (d_n % C == 1) begin
                d_idx = d_n / C;
                if (d_idx >= 1 && d_idx <= 8) begin
                    d_byte[d_idx-1] = TXD;
                end else if (d_idx == 9) begin
                    check("stop_bit", int'(TXD), 1);
                    check("frame_expected", int'(sb_q.size() != 0), 1);
                    if (sb_q.size() != 0) begin
                        d_exp = sb_q.pop_front();
                        check("frame_byte", int'(d_byte), int'(d_exp));
                    end
                    d_act = 0;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [7:0] b);
        wif.wr_valid = 1'b1;
        wif.wr_data  = b;
        @(posedge clk);
        #1;
        wif.wr_valid = 1'b0;
    endtask

    initial begin
        wif.wr_valid = 1'b0;
        wif.wr_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        idle(1);
        check("ready_after_reset", int'(wif.wr_ready), 1);

        // single 0xA5 frame
        tx_en = 1'b1;
        write(8'hA5);
        idle(FRAME + 6);

        // 0x00 then 0xFF back to back
        wif.wr_valid = 1'b1;
        wif.wr_data  = 8'h00;
        idle(1);
        wif.wr_data  = 8'hFF;
        idle(1);
        wif.wr_valid = 1'b0;
        idle(2 * FRAME + 6);

        // fill with tx_en low, fifth write dropped
        tx_en = 1'b0;
        for (int i = 0; i < 5; i++) write(8'(8'h10 + i));
        check("full_count", int'(fifo_count), D);
        check("full_ready", int'(wif.wr_ready), 0);
        idle(5);
        tx_en = 1'b1;
        idle(4 * FRAME + 10);

        // full FIFO with push held across the STOP->START pop edge
        for (int i = 0; i < 5; i++) write(8'($urandom));
        wif.wr_valid = 1'b1;
        for (int i = 0; i < FRAME + 8; i++) begin
            wif.wr_data = 8'($urandom);
            idle(1);
        end
        wif.wr_valid = 1'b0;
        idle(6 * FRAME);

        // reset mid DATA of 0x3C with two bytes queued
        write(8'h3C);
        write(8'h11);
        write(8'h22);
        idle(4 * C);
        #2 rstn = 1'b0;
        #1;
        check("rst_txd", int'(TXD), 1);
        check("rst_count", int'(fifo_count), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ready", int'(wif.wr_ready), 0);
        @(posedge clk);
        #1 rstn = 1'b1;
        idle(FRAME + 10);

        // tx_en dropped during the start bit of the first of two bytes
        tx_en = 1'b0;
        write(8'h5A);
        write(8'hC3);
        tx_en = 1'b1;
        idle(2);
        tx_en = 1'b0;
        idle(FRAME + 10);
        check("hold_count", int'(fifo_count), 1);
        tx_en = 1'b1;
        idle(FRAME + 10);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            wif.wr_valid = ($urandom_range(0, 3) == 0);
            wif.wr_data  = 8'($urandom);
            tx_en        = ($urandom_range(0, 9) != 0);
            idle(1);
        end
        wif.wr_valid = 1'b0;
        tx_en        = 1'b1;
        for (int i = 0; i < 8 * FRAME && sb_q.size() != 0; i++) idle(1);
        idle(FRAME);
        check("drain", sb_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
